// File: rtl/rfid_access_ctrl.sv
// rfid_access_ctrl: RFID tag access controller.
// A presented tag is captured, compared against a small programmable table of
// authorised tags, and either a grant (followed by a timed door unlock) or a
// denial is issued. Optional feature macro RFID_LOCKOUT_EN enables counting of
// consecutive denials and a timed lockout once MAX_FAILS is reached; without
// it, denials always return to IDLE and locked_out is tied low.
//
// Handshake: ready is high only in IDLE; a tag is accepted on a rising edge
// where valid && ready, and valid is ignored in every other state.
`timescale 1ns/1ps

module rfid_access_ctrl #(
  parameter int TAG_W          = 8,
  parameter int NUM_TAGS       = 4,
  parameter int DEFAULT_TAG    = 129,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  localparam int IDX_W         = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] rfid_data,
  input  logic             valid,
  output logic             ready,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_idx,
  input  logic [TAG_W-1:0] prog_tag,
  input  logic             prog_valid,
  output logic             access_granted,
  output logic             access_denied,
  output logic             door_unlock,
  output logic             locked_out,
  output logic [IDX_W-1:0] match_idx
);

  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    GRANT   = 3'd2,
    UNLOCK  = 3'd3,
    DENY    = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [TAG_W-1:0]   cap_tag, cap_tag_n;
  logic [TMR_W-1:0]   tmr, tmr_n;
  logic [IDX_W-1:0]   match_r, match_n;

`ifdef RFID_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  logic [FAIL_W-1:0]  fail_cnt, fail_n;
`endif

  // Authorised-tag table
  logic [TAG_W-1:0]   tbl_tag [NUM_TAGS];
  logic               tbl_vld [NUM_TAGS];

  // Table lookup result for the captured tag
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;

  // Table write port: any state, ignored when the index is out of range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        tbl_tag[i] <= (i == 0) ? TAG_W'(DEFAULT_TAG) : '0;
        tbl_vld[i] <= (i == 0);
      end
    end else if (prog_we && (int'(prog_idx) < NUM_TAGS)) begin
      tbl_tag[prog_idx] <= prog_tag;
      tbl_vld[prog_idx] <= prog_valid;
    end
  end

  // Lookup: scan high to low so the lowest matching index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (tbl_vld[i] && (tbl_tag[i] == cap_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cap_tag  <= '0;
      tmr      <= '0;
      match_r  <= '0;
`ifdef RFID_LOCKOUT_EN
      fail_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      cap_tag  <= cap_tag_n;
      tmr      <= tmr_n;
      match_r  <= match_n;
`ifdef RFID_LOCKOUT_EN
      fail_cnt <= fail_n;
`endif
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_n   = state;
    cap_tag_n = cap_tag;
    tmr_n     = tmr;
    match_n   = match_r;
`ifdef RFID_LOCKOUT_EN
    fail_n    = fail_cnt;
`endif
    case (state)
      IDLE: begin
        if (valid) begin
          cap_tag_n = rfid_data;
          state_n   = CHECK;
        end
      end
      CHECK: begin
        match_n = hit_idx;
        state_n = hit ? GRANT : DENY;
      end
      GRANT: begin
        tmr_n   = TMR_W'(UNLOCK_CYCLES - 1);
        state_n = UNLOCK;
`ifdef RFID_LOCKOUT_EN
        fail_n  = '0;
`endif
      end
      UNLOCK: begin
        if (tmr == '0) state_n = IDLE;
        else           tmr_n   = tmr - 1'b1;
      end
      DENY: begin
`ifdef RFID_LOCKOUT_EN
        if (fail_cnt < FAIL_W'(MAX_FAILS)) fail_n = fail_cnt + 1'b1;
        if (fail_n == FAIL_W'(MAX_FAILS)) begin
          tmr_n   = TMR_W'(LOCKOUT_CYCLES - 1);
          state_n = LOCKOUT;
        end else begin
          state_n = IDLE;
        end
`else
        state_n = IDLE;
`endif
      end
      LOCKOUT: begin
`ifdef RFID_LOCKOUT_EN
        if (tmr == '0) begin
          state_n = IDLE;
          fail_n  = '0;
        end else begin
          tmr_n = tmr - 1'b1;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  assign ready          = (state == IDLE);
  assign access_granted = (state == GRANT);
  assign access_denied  = (state == DENY);
  assign door_unlock    = (state == UNLOCK);
  assign match_idx      = (state == GRANT) ? match_r : '0;
`ifdef RFID_LOCKOUT_EN
  assign locked_out     = (state == LOCKOUT);
`else
  assign locked_out     = 1'b0;
`endif

endmodule
